// File: rtl/alu_pkg.sv
// Shared definitions for the stack16 bit-slice ALU: mode select, named opcodes
// and the status bundle captured by the flag register.
package alu_pkg;

    localparam logic M_ARITH = 1'b0;
    localparam logic M_LOGIC = 1'b1;

    localparam logic [4:0] OP_ADD    = 5'b01001;
    localparam logic [4:0] OP_SUB_M1 = 5'b00110;
    localparam logic [4:0] OP_DEC    = 5'b01111;
    localparam logic [4:0] OP_PASSA  = 5'b11111;
    localparam logic [4:0] OP_PASSB  = 5'b11010;
    localparam logic [4:0] OP_AND    = 5'b11011;
    localparam logic [4:0] OP_OR     = 5'b11110;
    localparam logic [4:0] OP_XOR    = 5'b10110;
    localparam logic [4:0] OP_NOTA   = 5'b10000;
    localparam logic [4:0] OP_ZERO   = 5'b10011;
    localparam logic [4:0] OP_ONES   = 5'b11100;

    typedef struct packed {
        logic carry;
        logic zero;
        logic minus1;
    } alu_status_t;

endpackage

// File: rtl/alu_slice4.sv
// One 4-bit 74181-equivalent slice: function output plus group propagate and
// generate for the lookahead unit in the top.
module alu_slice4
    import alu_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cin,
    output logic [3:0] f,
    output logic       p,
    output logic       g
);

    logic [3:0] t1;
    logic [3:0] t2;
    logic [3:0] p_bit;
    logic [3:0] g_bit;
    logic [3:0] c_bit;
    logic       ripple_acc;
    logic       gen_acc;

    // T2 can only be set where A is set, so T1 covers it; p/g are the usual half-add terms
    always_comb begin
        t1    = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        t2    = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
        p_bit = t1 ^ t2;
        g_bit = t1 & t2;
    end

    always_comb begin
        c_bit      = '0;
        ripple_acc = cin;
        for (int i = 0; i < 4; i++) begin
            c_bit[i]   = ripple_acc;
            ripple_acc = g_bit[i] | (p_bit[i] & ripple_acc);
        end
    end

    always_comb begin
        gen_acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            gen_acc = g_bit[i] | (p_bit[i] & gen_acc);
        end
        g = gen_acc;
        p = &p_bit;
    end

    // Logic mode is the inverted half-sum with all internal carries suppressed
    always_comb begin
        if (m == M_LOGIC) begin
            f = ~p_bit;
        end else begin
            f = p_bit ^ c_bit;
        end
    end

endmodule

// File: rtl/bitslice_alu.sv
// 16-bit 74181-style ALU built from 4-bit slices with group carry lookahead,
// optional byte swap, combinational status and a registered flag copy.
module bitslice_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       Op,
    input  logic             Swap,
    input  logic             Cin,
    input  logic             FlagEn,
    output logic [WIDTH-1:0] Q,
    output logic             Carry,
    output logic             Zero,
    output logic             Minus1,
    output logic             FlagC,
    output logic             FlagZ,
    output logic             FlagM1
);

    localparam int NSL = WIDTH / 4;

    logic             logic_mode;
    logic [WIDTH-1:0] f;
    logic [NSL-1:0]   grp_p;
    logic [NSL-1:0]   grp_g;
    logic [NSL:0]     carry;
    logic             look_acc;
    alu_status_t      status;
    alu_status_t      flag_d;
    alu_status_t      flag_q;

    assign logic_mode = (Op[4] == M_LOGIC);

    for (genvar i = 0; i < NSL; i++) begin : g_slice
        alu_slice4 u_slice (
            .a   (A[4*i +: 4]),
            .b   (B[4*i +: 4]),
            .s   (Op[3:0]),
            .m   (logic_mode),
            .cin (carry[i]),
            .f   (f[4*i +: 4]),
            .p   (grp_p[i]),
            .g   (grp_g[i])
        );
    end

    // Each slice carry is a flat function of group P/G and Cin, never of a lower slice's carry
    always_comb begin
        carry    = '0;
        carry[0] = Cin;
        look_acc = 1'b0;
        for (int k = 0; k < NSL; k++) begin
            look_acc = Cin;
            for (int j = 0; j <= k; j++) begin
                look_acc = grp_g[j] | (grp_p[j] & look_acc);
            end
            carry[k+1] = look_acc;
        end
    end

    always_comb begin
        if (Swap) begin
            Q = {f[7:0], f[WIDTH-1:8]};
        end else begin
            Q = f;
        end
    end

    always_comb begin
        status.carry  = carry[NSL] & ~logic_mode;
        status.zero   = (Q == '0);
        status.minus1 = &Q;
    end

    assign Carry  = status.carry;
    assign Zero   = status.zero;
    assign Minus1 = status.minus1;

    always_comb begin
        flag_d = flag_q;
        if (FlagEn) begin
            flag_d = status;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign FlagC  = flag_q.carry;
    assign FlagZ  = flag_q.zero;
    assign FlagM1 = flag_q.minus1;

endmodule

// File: tb/tb_bitslice_alu.sv
// Self-checking bench for bitslice_alu: directed vectors plus randomized
// operations and flag-register activity against a function-table model.
module tb_bitslice_alu;
    import alu_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  op;
    logic        swap;
    logic        cin;
    logic        flag_en;
    logic [15:0] q;
    logic        carry;
    logic        zero;
    logic        minus1;
    logic        flag_c;
    logic        flag_z;
    logic        flag_m1;

    int assert_count = 0;
    int fail_count   = 0;

    logic exp_fc;
    logic exp_fz;
    logic exp_fm1;

    bitslice_alu #(.WIDTH(16)) dut (
        .clk    (clk),
        .rst    (rst),
        .A      (a),
        .B      (b),
        .Op     (op),
        .Swap   (swap),
        .Cin    (cin),
        .FlagEn (flag_en),
        .Q      (q),
        .Carry  (carry),
        .Zero   (zero),
        .Minus1 (minus1),
        .FlagC  (flag_c),
        .FlagZ  (flag_z),
        .FlagM1 (flag_m1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {carry, Q} from the published function tables
    function automatic logic [16:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic [4:0] mop, input logic mcin,
                                          input logic mswap);
        logic [15:0] x;
        logic [15:0] y;
        logic [16:0] sum;
        logic [15:0] fres;
        logic        c;
        x = 16'h0;
        y = 16'h0;
        c = 1'b0;
        if (mop[4]) begin
            case (mop[3:0])
                4'b0000: fres = ~ma;
                4'b0001: fres = ~(ma | mb);
                4'b0010: fres = ~ma & mb;
                4'b0011: fres = 16'h0000;
                4'b0100: fres = ~(ma & mb);
                4'b0101: fres = ~mb;
                4'b0110: fres = ma ^ mb;
                4'b0111: fres = ma & ~mb;
                4'b1000: fres = ~ma | mb;
                4'b1001: fres = ~(ma ^ mb);
                4'b1010: fres = mb;
                4'b1011: fres = ma & mb;
                4'b1100: fres = 16'hFFFF;
                4'b1101: fres = ma | ~mb;
                4'b1110: fres = ma | mb;
                default: fres = ma;
            endcase
        end else begin
            case (mop[3:0])
                4'b0000: begin x = ma;        y = 16'h0000;  end
                4'b0001: begin x = ma | mb;   y = 16'h0000;  end
                4'b0010: begin x = ma | ~mb;  y = 16'h0000;  end
                4'b0011: begin x = 16'hFFFF;  y = 16'h0000;  end
                4'b0100: begin x = ma;        y = ma & ~mb;  end
                4'b0101: begin x = ma | mb;   y = ma & ~mb;  end
                4'b0110: begin x = ma;        y = ~mb;       end
                4'b0111: begin x = ma & ~mb;  y = 16'hFFFF;  end
                4'b1000: begin x = ma;        y = ma & mb;   end
                4'b1001: begin x = ma;        y = mb;        end
                4'b1010: begin x = ma | ~mb;  y = ma & mb;   end
                4'b1011: begin x = ma & mb;   y = 16'hFFFF;  end
                4'b1100: begin x = ma;        y = ma;        end
                4'b1101: begin x = ma | mb;   y = ma;        end
                4'b1110: begin x = ma | ~mb;  y = ma;        end
                default: begin x = ma;        y = 16'hFFFF;  end
            endcase
            sum  = {1'b0, x} + {1'b0, y} + {16'h0, mcin};
            fres = sum[15:0];
            c    = sum[16];
        end
        if (mswap) fres = {fres[7:0], fres[15:8]};
        return {c, fres};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Drives operands mid-cycle so flag captures see stable inputs at the next posedge
    task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb,
                                 input logic [4:0] top, input logic tswap,
                                 input logic tcin);
        @(negedge clk);
        a    = ta;
        b    = tb;
        op   = top;
        swap = tswap;
        cin  = tcin;
        #1;
    endtask

    task automatic checkComb(input string tag, input logic [15:0] eq, input logic ec,
                             input logic ez, input logic em1);
        checkOutput({tag, ".Q"}, {16'h0, q}, {16'h0, eq});
        checkOutput({tag, ".Carry"}, {31'h0, carry}, {31'h0, ec});
        checkOutput({tag, ".Zero"}, {31'h0, zero}, {31'h0, ez});
        checkOutput({tag, ".Minus1"}, {31'h0, minus1}, {31'h0, em1});
    endtask

    task automatic checkFlags(input string tag);
        checkOutput({tag, ".FlagC"}, {31'h0, flag_c}, {31'h0, exp_fc});
        checkOutput({tag, ".FlagZ"}, {31'h0, flag_z}, {31'h0, exp_fz});
        checkOutput({tag, ".FlagM1"}, {31'h0, flag_m1}, {31'h0, exp_fm1});
    endtask

    initial begin
        logic [16:0] m;
        rst     = 1'b1;
        flag_en = 1'b0;
        a = 16'h0; b = 16'h0; op = OP_ADD; swap = 1'b0; cin = 1'b0;

        @(negedge clk);
        rst = 1'b0;
        exp_fc = 1'b0; exp_fz = 1'b0; exp_fm1 = 1'b0;
        checkFlags("reset");

        applyStimulus(16'h4444, 16'h2345, OP_ADD, 1'b1, 1'b0);
        checkComb("add_swap", 16'h8967, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'hF00F, 16'hC7C8, OP_ADD, 1'b0, 1'b0);
        checkComb("add_carry", 16'hB7D7, 1'b1, 1'b0, 1'b0);
        applyStimulus(16'h3CC3, 16'h7CC7, OP_ADD, 1'b1, 1'b0);
        checkComb("add_nocarry_kept", 16'h8AB9, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'hFF00, 16'h0100, OP_ADD, 1'b0, 1'b0);
        checkComb("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'h0000, 16'h0000, OP_ADD, 1'b1, 1'b0);
        checkComb("add_zero", 16'h0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(16'h7777, 16'h8888, OP_ADD, 1'b0, 1'b0);
        checkComb("add_ones", 16'hFFFF, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'h0005, 16'h0007, OP_SUB_M1, 1'b0, 1'b1);
        checkComb("sub", 16'hFFFE, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h1234, 16'h5678, 5'b00011, 1'b0, 1'b1);
        checkComb("ones_plus1", 16'h0000, 1'b1, 1'b1, 1'b0);
        applyStimulus(16'hF0F0, 16'hFF00, OP_AND, 1'b0, 1'b1);
        checkComb("and", 16'hF000, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'hF0F0, 16'hFF00, OP_OR, 1'b0, 1'b1);
        checkComb("or", 16'hFFF0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'hF0F0, 16'hFF00, OP_XOR, 1'b0, 1'b0);
        checkComb("xor", 16'h0FF0, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'hF0F0, 16'hFF00, OP_ZERO, 1'b0, 1'b1);
        checkComb("zero_op", 16'h0000, 1'b0, 1'b1, 1'b0);
        applyStimulus(16'h0000, 16'h0000, OP_DEC, 1'b0, 1'b0);
        checkComb("dec_zero", 16'hFFFF, 1'b0, 1'b0, 1'b1);

        applyStimulus(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 1'b0);
        flag_en = 1'b1;
        @(negedge clk);
        flag_en = 1'b0;
        exp_fc = 1'b1; exp_fz = 1'b1; exp_fm1 = 1'b0;
        checkFlags("flag_capture");
        applyStimulus(16'h0001, 16'h0001, OP_ADD, 1'b0, 1'b0);
        @(negedge clk);
        checkFlags("flag_hold");
        applyStimulus(16'hFFFF, 16'h0001, OP_ADD, 1'b0, 1'b0);
        rst = 1'b1;
        flag_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        flag_en = 1'b0;
        exp_fc = 1'b0; exp_fz = 1'b0; exp_fm1 = 1'b0;
        checkFlags("flag_rst_prio");

        for (int i = 0; i < 400; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        do_rst;
            logic        do_en;
            ra = 16'($urandom);
            rb = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rb = ~ra;
            if ($urandom_range(0, 7) == 0) rb = 16'h0000 - ra;
            applyStimulus(ra, rb, 5'($urandom), 1'($urandom), 1'($urandom));
            m = model(a, b, op, cin, swap);
            checkComb("rand", m[15:0], m[16], (m[15:0] == 16'h0), (m[15:0] == 16'hFFFF));
            do_rst  = ($urandom_range(0, 15) == 0);
            do_en   = 1'($urandom);
            rst     = do_rst;
            flag_en = do_en;
            @(negedge clk);
            if (do_rst) begin
                exp_fc = 1'b0; exp_fz = 1'b0; exp_fm1 = 1'b0;
            end else if (do_en) begin
                exp_fc  = m[16];
                exp_fz  = (m[15:0] == 16'h0);
                exp_fm1 = (m[15:0] == 16'hFFFF);
            end
            rst     = 1'b0;
            flag_en = 1'b0;
            checkFlags("rand_flags");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
